alu_sequencer: RTL and testbench

//  Issue-side controller for the alu datapath. It accepts encoded instructions over a

---
 rtl/alu_sequencer.sv | 112 +++++++++++
 tb/tb_alu_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue-side controller for an external combinational alu. Accepts one encoded
// instruction at a time, reads operands from a local register file, drives the
// alu, captures its result/flags, writes the result back and offers it on a
// valid/ready response port.
module alu_sequencer #(
    parameter int BW   = 16,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG),
    localparam int IW  = 3 + 3 * RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    input  logic          cfg_we,
    input  logic [RW-1:0] cfg_addr,
    input  logic [BW-1:0] cfg_wdata,
    output logic [2:0]    alu_opcode,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [BW-1:0] res_data,
    output logic [2:0]    res_flags,
    output logic [RW-1:0] res_rd,
    output logic [2:0]    flags_q,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [RW-1:0] rd_q, ra_q, rb_q;
    logic [BW-1:0] rf [NREG];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one cycle each in READ and EXEC, RESP waits for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);
    assign res_valid   = (state == RESP);
    assign busy        = (state != IDLE);

    // Latch instruction fields on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (state == IDLE && instr_valid) begin
            {op_q, rd_q, ra_q, rb_q} <= instr;
        end
    end

    // Alu inputs are registered in READ and otherwise hold their last value
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if (state == READ) begin
            alu_opcode <= op_q;
            alu_a      <= rf[ra_q];
            alu_b      <= rf[rb_q];
        end
    end

    // Capture alu result in EXEC; held through RESP and beyond
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data  <= '0;
            res_flags <= '0;
            res_rd    <= '0;
            flags_q   <= '0;
        end else if (state == EXEC) begin
            res_data  <= alu_out;
            res_flags <= alu_flags;
            res_rd    <= rd_q;
            flags_q   <= alu_flags;
        end
    end

    // Register file: preload port first so a same-index EXEC writeback overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (cfg_we)          rf[cfg_addr] <= cfg_wdata;
            if (state == EXEC)   rf[rd_q]     <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural alu stub, directed scenarios, then
// randomized traffic checked by a queue-based scoreboard and monitor.
module tb_alu_sequencer;

    localparam int BW = 16;
    localparam int NREG = 8;
    localparam int RW = 3;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_INC = 3'd5, OP_PA  = 3'd6, OP_PB = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [11:0]   instr;
    logic          cfg_we;
    logic [RW-1:0] cfg_addr;
    logic [BW-1:0] cfg_wdata;
    logic [2:0]    alu_opcode;
    logic [BW-1:0] alu_a, alu_b, alu_out;
    logic [2:0]    alu_flags;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [BW-1:0] res_data;
    logic [2:0]    res_flags;
    logic [RW-1:0] res_rd;
    logic [2:0]    flags_q;
    logic          busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never
    bit rand_cfg = 0;

    alu_sequencer #(.BW(BW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .res_rd(res_rd),
        .flags_q(flags_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Alu behaviour: returns {overflow, negative, zero, result}
    function automatic logic [18:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        r = 16'h0;
        v = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_INC: begin r = a + 16'd1; v = (a == 16'h7FFF); end
            OP_PA:  r = a;
            default: r = b;
        endcase
        return {v, r[15], (r == 16'h0), r};
    endfunction

    logic [18:0] alu_res;
    always_comb alu_res = alu_fn(alu_opcode, alu_a, alu_b);
    assign alu_out   = alu_res[15:0];
    assign alu_flags = alu_res[18:16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Consumer ready generator
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 2) != 0);
            default: res_ready = 1'b0;
        endcase
    end

    typedef struct {
        logic [15:0] data;
        logic [2:0]  flags;
        logic [2:0]  rd;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rf [NREG];
    int          wb_cnt = 0;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    bit          prev_v = 0, prev_rdy = 0;
    logic [15:0] h_data;
    logic [2:0]  h_flags, h_rd;

    // Reference model and monitor, sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        logic [18:0] r;
        cyc++;
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_rf[i] = 16'h0;
            wb_cnt = 0;
            sb.delete();
            prev_v = 0;
            prev_rdy = 0;
        end else begin
            // monitor
            if (res_valid) begin
                if (!prev_v) begin
                    chk("res_expected", (sb.size() > 0), 1);
                    if (sb.size() > 0) chk("latency", cyc, sb[0].due);
                end else if (!prev_rdy) begin
                    chk("hold_data", res_data, h_data);
                    chk("hold_flags", res_flags, h_flags);
                    chk("hold_rd", res_rd, h_rd);
                end
                if (res_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_flags", res_flags, e.flags);
                    chk("res_rd", res_rd, e.rd);
                    chk("flags_q", flags_q, e.flags);
                end
            end else if (prev_v && !prev_rdy) begin
                chk("hold_valid", res_valid, 1);
            end
            prev_v = res_valid;
            prev_rdy = res_ready;
            h_data = res_data;
            h_flags = res_flags;
            h_rd = res_rd;

            // model: preload, then writeback (wins on same index), then new issue
            if (cfg_we) m_rf[cfg_addr] = cfg_wdata;
            if (wb_cnt > 0) begin
                wb_cnt--;
                if (wb_cnt == 0) m_rf[wb_rd] = wb_data;
            end
            if (instr_valid && instr_ready) begin
                r = alu_fn(instr[11:9], m_rf[instr[5:3]], m_rf[instr[2:0]]);
                e.data = r[15:0];
                e.flags = r[18:16];
                e.rd = instr[8:6];
                e.due = cyc + 3;
                sb.push_back(e);
                wb_cnt = 2;
                wb_rd = instr[8:6];
                wb_data = r[15:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_cfg) begin
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_addr = RW'($urandom_range(0, NREG - 1));
            cfg_wdata = 16'($urandom);
        end else begin
            cfg_we = 1'b0;
        end
    endtask

    task automatic cfg(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        step();
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb);
        bit ok;
        ok = 0;
        instr = {op, rd, ra, rb};
        instr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1; break; end
            step();
        end
        if (!ok) chk("accept_timeout", 0, 1);
        step();
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state, then every entry reads back zero
        @(negedge clk);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_res_data", res_data, 0);
        step();
        for (int i = 0; i < NREG; i++) issue(OP_PA, 3'(i), 3'(i), 3'd0);
        wait_idle();

        // signed overflow on ADD
        cfg(3'd1, 16'h7FFF);
        cfg(3'd2, 16'h0001);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2);
        wait_idle();
        chk("add_data", res_data, 16'h8000);
        chk("add_flags", res_flags, 3'b110);
        chk("add_rd", res_rd, 3);

        // zero result and dependent writeback
        cfg(3'd4, 16'h5555);
        issue(OP_SUB, 3'd4, 3'd2, 3'd2);
        issue(OP_PB, 3'd5, 3'd0, 3'd4);
        wait_idle();
        chk("passb_data", res_data, 16'h0000);
        chk("passb_flags", res_flags, 3'b001);

        // backpressure with a pending second instruction
        rdy_mode = 2;
        step();
        issue(OP_ADD, 3'd6, 3'd1, 3'd1);
        instr = {OP_XOR, 3'd7, 3'd1, 3'd2};
        instr_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; break; end
        end
        chk("bp_res_valid", ok, 1);
        repeat (5) begin
            chk("bp_instr_ready", instr_ready, 0);
            @(negedge clk);
        end
        rdy_mode = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin ok = 1; break; end
        end
        chk("bp_handshake", ok, 1);
        @(negedge clk);
        chk("bp_next_accept", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        wait_idle();

        // preload colliding with EXEC writeback: writeback wins
        cfg(3'd1, 16'h0010);
        issue(OP_INC, 3'd3, 3'd1, 3'd0);
        step();
        cfg_we = 1'b1;
        cfg_addr = 3'd3;
        cfg_wdata = 16'h1234;
        step();
        wait_idle();
        issue(OP_PA, 3'd6, 3'd3, 3'd0);
        wait_idle();
        chk("collide_r3", res_data, 16'h0011);

        // reset during EXEC drops the instruction and clears the regfile
        issue(OP_ADD, 3'd2, 3'd1, 3'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_ready", instr_ready, 1);
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_valid", res_valid, 0);
        repeat (4) @(negedge clk);
        step();
        issue(OP_PA, 3'd0, 3'd1, 3'd0);
        wait_idle();
        chk("rst_exec_r1", res_data, 16'h0000);

        // randomized traffic with random preloads and backpressure
        rand_cfg = 1;
        rdy_mode = 1;
        repeat (80) issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        rand_cfg = 0;
        rdy_mode = 0;
        wait_idle();
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
